// File: rtl/pipe_hazard_pkg.sv
// Shared types for the RV32 pipeline hazard/forwarding controller.
// Forward select encodings, memory-latency FSM states, result-source code.
package pipe_hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_e;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mem_state_e;

  localparam logic [1:0] LOAD_RESULT_SRC = 2'b01;

endpackage

// File: rtl/pipeline_hazard_ctrl_mem_lat_fsm.sv
// Holds the M stage for MEM_LAT extra cycles per data-memory access.
// Every access, including back-to-back ones, pays the full latency.
module mem_lat_fsm
  import pipe_hazard_pkg::*;
#(
  parameter int unsigned MEM_LAT = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic MemAccessM,
  output logic mem_stall,
  output logic MemBusy
);

  localparam int unsigned CW =
    (MEM_LAT > 0) ? $clog2(MEM_LAT + 1) : 1;
  localparam logic [CW-1:0] CNT_INIT =
    CW'((MEM_LAT > 0) ? MEM_LAT - 1 : 0);

  mem_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_stall = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (MemAccessM && MEM_LAT > 0) begin
          mem_stall = 1'b1;
          state_d   = BUSY;
          cnt_d     = CNT_INIT;
        end
      end
      BUSY: begin
        // cnt==0 is the release cycle: M advances on this edge
        if (cnt_q != '0) begin
          mem_stall = 1'b1;
          cnt_d     = cnt_q - 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign MemBusy = (state_q == BUSY);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard, forwarding and redirect control for the 5-stage RV32 pipeline.
// Priority: memory stall > redirect > data hazard.
module pipeline_hazard_ctrl
  import pipe_hazard_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned MEM_LAT = 0,
  parameter int unsigned FWD_EN  = 1,
  parameter int unsigned CNT_W   = 32,
  localparam int unsigned SC_W   = (CNT_W != 0) ? CNT_W : XLEN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] Rs1D,
  input  logic [REG_AW-1:0] Rs2D,
  input  logic [REG_AW-1:0] Rs1E,
  input  logic [REG_AW-1:0] Rs2E,
  input  logic [REG_AW-1:0] RdE,
  input  logic [REG_AW-1:0] RdM,
  input  logic [REG_AW-1:0] RdW,
  input  logic              RegWriteE,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic              LoadE,
  input  logic              MemAccessM,
  input  logic              PCSrcE,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              RedirectE,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              StallM,
  output logic              FlushD,
  output logic              FlushE,
  output logic              FlushW,
  output logic              MemBusy,
  output logic [SC_W-1:0]   StallCount
);

  logic mem_stall;
  logic raw_hz, lu_fwd, lu_hz;
  logic [SC_W-1:0] stall_cnt_q, stall_cnt_d;

  mem_lat_fsm #(
    .MEM_LAT(MEM_LAT)
  ) u_mem_lat (
    .clk       (clk),
    .rst       (rst),
    .MemAccessM(MemAccessM),
    .mem_stall (mem_stall),
    .MemBusy   (MemBusy)
  );

  function automatic logic hit(
    input logic              we,
    input logic [REG_AW-1:0] rd,
    input logic [REG_AW-1:0] rs
  );
    return we && (rd != '0) && (rd == rs);
  endfunction

  function automatic fwd_sel_e fwd_of(
    input logic [REG_AW-1:0] rs
  );
    if (hit(RegWriteM, RdM, rs)) return FWD_M;
    if (hit(RegWriteW, RdW, rs)) return FWD_W;
    return FWD_RF;
  endfunction

  // no regfile write-through, so a W match must also stall
  assign raw_hz =
    hit(RegWriteE, RdE, Rs1D) || hit(RegWriteE, RdE, Rs2D) ||
    hit(RegWriteM, RdM, Rs1D) || hit(RegWriteM, RdM, Rs2D) ||
    hit(RegWriteW, RdW, Rs1D) || hit(RegWriteW, RdW, Rs2D);

  assign lu_fwd = hit(LoadE, RdE, Rs1D) || hit(LoadE, RdE, Rs2D);
  assign lu_hz  = (FWD_EN != 0) ? lu_fwd : raw_hz;

  always_comb begin
    ForwardAE = FWD_RF;
    ForwardBE = FWD_RF;
    RedirectE = 1'b0;
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    FlushD    = 1'b1;
    FlushE    = 1'b1;
    FlushW    = 1'b1;
    if (rst) begin
      if (FWD_EN != 0) begin
        ForwardAE = fwd_of(Rs1E);
        ForwardBE = fwd_of(Rs2E);
      end
      RedirectE = PCSrcE && !mem_stall;
      StallM    = mem_stall;
      StallE    = mem_stall;
      FlushW    = mem_stall;
      // a redirect squashes D, so its hazard never stalls
      StallF    = mem_stall || (lu_hz && !RedirectE);
      StallD    = StallF;
      FlushD    = RedirectE;
      FlushE    = RedirectE || (lu_hz && !mem_stall);
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (StallF && stall_cnt_q != '1) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign StallCount = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: two configurations driven in lockstep,
// directed scenarios plus random traffic against a cycle-age reference.
module tb_pipeline_hazard_ctrl;

  typedef struct packed {
    logic [1:0] fa;
    logic [1:0] fb;
    logic red, sf, sd, se, sm, fd, fe, fw, busy;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic RegWriteE, RegWriteM, RegWriteW;
  logic LoadE, MemAccessM, PCSrcE;

  logic [1:0] fa[2], fb[2];
  logic red[2], sf[2], sd[2], se[2], sm[2];
  logic fd[2], fe[2], fw[2], busy[2];
  logic [3:0]  sc0;
  logic [31:0] sc1;
  obs_t act[2];

  int checks = 0;
  int failures = 0;

  int lat[2] = '{3, 2};
  bit fen[2] = '{1'b1, 1'b0};
  logic [63:0] cmax[2] = '{64'd15, 64'hFFFF_FFFF};
  int age_q[2] = '{-1, -1};
  logic [63:0] cnt_m[2] = '{64'd0, 64'd0};

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(
    .XLEN(32), .REG_AW(5), .MEM_LAT(3), .FWD_EN(1), .CNT_W(4)
  ) d0 (
    .clk(clk), .rst(rst),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM),
    .RegWriteW(RegWriteW), .LoadE(LoadE),
    .MemAccessM(MemAccessM), .PCSrcE(PCSrcE),
    .ForwardAE(fa[0]), .ForwardBE(fb[0]), .RedirectE(red[0]),
    .StallF(sf[0]), .StallD(sd[0]), .StallE(se[0]), .StallM(sm[0]),
    .FlushD(fd[0]), .FlushE(fe[0]), .FlushW(fw[0]),
    .MemBusy(busy[0]), .StallCount(sc0)
  );

  pipeline_hazard_ctrl #(
    .XLEN(32), .REG_AW(5), .MEM_LAT(2), .FWD_EN(0), .CNT_W(32)
  ) d1 (
    .clk(clk), .rst(rst),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM),
    .RegWriteW(RegWriteW), .LoadE(LoadE),
    .MemAccessM(MemAccessM), .PCSrcE(PCSrcE),
    .ForwardAE(fa[1]), .ForwardBE(fb[1]), .RedirectE(red[1]),
    .StallF(sf[1]), .StallD(sd[1]), .StallE(se[1]), .StallM(sm[1]),
    .FlushD(fd[1]), .FlushE(fe[1]), .FlushW(fw[1]),
    .MemBusy(busy[1]), .StallCount(sc1)
  );

  assign act[0] = {fa[0], fb[0], red[0], sf[0], sd[0], se[0], sm[0],
                   fd[0], fe[0], fw[0], busy[0]};
  assign act[1] = {fa[1], fb[1], red[1], sf[1], sd[1], se[1], sm[1],
                   fd[1], fe[1], fw[1], busy[1]};

  // Reference: an access is tracked by its age in cycles since it entered M.
  function automatic int cur_age(int d);
    if (age_q[d] < 0 && MemAccessM && lat[d] > 0) return 0;
    return age_q[d];
  endfunction

  function automatic int next_age(int d);
    int a = cur_age(d);
    if (a < 0 || a == lat[d]) return -1;
    return a + 1;
  endfunction

  function automatic logic [1:0] ref_fwd(logic [4:0] rs);
    if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
    if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit ref_raw();
    logic [4:0] rd[3];
    logic we[3];
    bit r = 0;
    rd = '{RdE, RdM, RdW};
    we = '{RegWriteE, RegWriteM, RegWriteW};
    for (int k = 0; k < 3; k++)
      if (we[k] && rd[k] != 0 && (rd[k] == Rs1D || rd[k] == Rs2D))
        r = 1;
    return r;
  endfunction

  function automatic obs_t model(int d);
    obs_t e = '0;
    int a;
    bit ms, lu;
    if (!rst) begin
      e.fd = 1; e.fe = 1; e.fw = 1;
      return e;
    end
    a = cur_age(d);
    ms = (a >= 0) && (a < lat[d]);
    e.busy = (a >= 1);
    if (fen[d]) begin
      e.fa = ref_fwd(Rs1E);
      e.fb = ref_fwd(Rs2E);
      lu = LoadE && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
    end else begin
      lu = ref_raw();
    end
    e.red = PCSrcE && !ms;
    e.sm = ms; e.se = ms; e.fw = ms;
    e.sf = ms || (lu && !e.red);
    e.sd = e.sf;
    e.fd = e.red;
    e.fe = e.red || (lu && !ms);
    return e;
  endfunction

  task automatic tick();
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        if (model(d).sf && cnt_m[d] < cmax[d]) cnt_m[d]++;
        age_q[d] = next_age(d);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
    {RegWriteE, RegWriteM, RegWriteW} = '0;
    {LoadE, MemAccessM, PCSrcE} = '0;
  endtask

  task automatic idle(int n);
    clr();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      tick();
    end
  endtask

  task automatic test_reset();
    clr();
    PCSrcE = 1;
    #2;
    checks++;
    if (act[0] !== 13'b00_00_0000000_1110) begin
      failures++;
      $display("FAIL reset_out got=%b exp=%b", act[0],
               13'b00_00_0000000_1110);
    end
    checks++;
    if (sc0 !== 4'd0 || sc1 !== 32'd0) begin
      failures++;
      $display("FAIL reset_cnt got=%0d/%0d exp=0/0", sc0, sc1);
    end
    @(posedge clk);
    #1;
    rst = 1;
    clr();
  endtask

  task automatic test_forwarding();
    clr();
    RdM = 5; RegWriteM = 1; RdW = 5; RegWriteW = 1;
    Rs1E = 5; Rs2E = 5;
    @(negedge clk);
    checks++;
    if (fa[0] !== 2'b10 || fa[1] !== 2'b00) begin
      failures++;
      $display("FAIL fwd_m_prio got=%b/%b exp=10/00", fa[0], fa[1]);
    end
    tick();
    RdM = 0;
    @(negedge clk);
    checks++;
    if (fa[0] !== 2'b01 || fb[0] !== 2'b01) begin
      failures++;
      $display("FAIL fwd_w got=%b/%b exp=01/01", fa[0], fb[0]);
    end
    tick();
    Rs2E = 0; RdW = 0;
    @(negedge clk);
    checks++;
    if (fb[0] !== 2'b00 || fa[0] !== 2'b00) begin
      failures++;
      $display("FAIL fwd_x0 got=%b/%b exp=00/00", fa[0], fb[0]);
    end
    tick();
  endtask

  task automatic test_load_use();
    clr();
    LoadE = 1; RegWriteE = 1; RdE = 7; Rs2D = 7;
    @(negedge clk);
    checks++;
    if ({sf[0], sd[0], fe[0], fd[0]} !== 4'b1110) begin
      failures++;
      $display("FAIL lu_stall got=%b exp=1110",
               {sf[0], sd[0], fe[0], fd[0]});
    end
    tick();
    PCSrcE = 1;
    @(negedge clk);
    checks++;
    if ({sf[0], sd[0], fe[0], fd[0]} !== 4'b0011) begin
      failures++;
      $display("FAIL lu_redirect got=%b exp=0011",
               {sf[0], sd[0], fe[0], fd[0]});
    end
    tick();
    clr();
  endtask

  task automatic test_mem_latency();
    idle(5);
    MemAccessM = 1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (sm[0] !== ((i % 4) != 3) || se[0] !== sm[0] ||
          fw[0] !== sm[0] || busy[0] !== ((i % 4) != 0)) begin
        failures++;
        $display("FAIL mem_lat c%0d got sm=%b se=%b fw=%b busy=%b exp sm=%b busy=%b",
                 i, sm[0], se[0], fw[0], busy[0],
                 (i % 4) != 3, (i % 4) != 0);
      end
      tick();
    end
    clr();
  endtask

  task automatic test_redirect_gate();
    idle(5);
    MemAccessM = 1; PCSrcE = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (red[1] !== (i == 2) || fd[1] !== (i == 2)) begin
        failures++;
        $display("FAIL redir_gate c%0d got red=%b fd=%b exp=%b",
                 i, red[1], fd[1], i == 2);
      end
      tick();
    end
    clr();
    @(negedge clk);
    checks++;
    if (red[1] !== 1'b0) begin
      failures++;
      $display("FAIL redir_after got=%b exp=0", red[1]);
    end
    tick();
  endtask

  task automatic test_stall_only();
    idle(4);
    RdW = 3; RegWriteW = 1; Rs1D = 3; Rs1E = 3;
    @(negedge clk);
    checks++;
    if ({sf[1], sd[1], fe[1]} !== 3'b111 || fa[1] !== 2'b00 ||
        fb[1] !== 2'b00 || fa[0] !== 2'b01) begin
      failures++;
      $display("FAIL stall_only got s=%b fa=%b/%b exp s=111 fa=00/01",
               {sf[1], sd[1], fe[1]}, fa[1], fa[0]);
    end
    tick();
    Rs1D = 0; RdW = 0;
    @(negedge clk);
    checks++;
    if ({sf[1], sd[1], fe[1]} !== 3'b000) begin
      failures++;
      $display("FAIL stall_only_x0 got=%b exp=000",
               {sf[1], sd[1], fe[1]});
    end
    tick();
    clr();
  endtask

  task automatic test_reset_mid_busy();
    idle(5);
    MemAccessM = 1; PCSrcE = 1;
    @(negedge clk);
    tick();
    @(negedge clk);
    tick();
    checks++;
    if (busy[0] !== 1'b1 || sm[0] !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset busy=%b sm=%b exp=1/1", busy[0], sm[0]);
    end
    #2;
    rst = 0;
    #1;
    checks++;
    if (act[0] !== 13'b00_00_0000000_1110 || sc0 !== 4'd0) begin
      failures++;
      $display("FAIL async_reset got=%b cnt=%0d exp=%b cnt=0",
               act[0], sc0, 13'b00_00_0000000_1110);
    end
    for (int d = 0; d < 2; d++) begin
      age_q[d] = -1;
      cnt_m[d] = 0;
    end
    @(posedge clk);
    #1;
    rst = 1;
    clr();
  endtask

  task automatic test_stall_count();
    clr();
    LoadE = 1; RegWriteE = 1; RdE = 7; Rs2D = 7;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      tick();
    end
    @(negedge clk);
    checks++;
    if (sc0 !== 4'd15) begin
      failures++;
      $display("FAIL cnt_sat got=%0d exp=15", sc0);
    end
    checks++;
    if (sc1 !== 32'd20) begin
      failures++;
      $display("FAIL cnt_wide got=%0d exp=20", sc1);
    end
    tick();
    clr();
  endtask

  task automatic test_random();
    obs_t e;
    for (int i = 0; i < 400; i++) begin
      Rs1D = 5'($urandom_range(0, 3));
      Rs2D = 5'($urandom_range(0, 3));
      Rs1E = 5'($urandom_range(0, 3));
      Rs2E = 5'($urandom_range(0, 3));
      RdE = 5'($urandom_range(0, 3));
      RdM = 5'($urandom_range(0, 3));
      RdW = 5'($urandom_range(0, 3));
      RegWriteE = 1'($urandom_range(0, 1));
      RegWriteM = 1'($urandom_range(0, 1));
      RegWriteW = 1'($urandom_range(0, 1));
      LoadE = ($urandom_range(0, 3) == 0);
      MemAccessM = ($urandom_range(0, 9) < 3);
      PCSrcE = ($urandom_range(0, 4) == 0);
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        e = model(d);
        checks++;
        if (act[d] !== e) begin
          failures++;
          $display("FAIL rand_out d%0d c%0d got=%b exp=%b",
                   d, i, act[d], e);
        end
      end
      checks++;
      if ({60'b0, sc0} !== cnt_m[0] || {32'b0, sc1} !== cnt_m[1]) begin
        failures++;
        $display("FAIL rand_cnt c%0d got=%0d/%0d exp=%0d/%0d",
                 i, sc0, sc1, cnt_m[0], cnt_m[1]);
      end
      tick();
    end
    clr();
  endtask

  initial begin
    test_reset();
    test_forwarding();
    test_load_use();
    test_mem_latency();
    test_redirect_gate();
    test_stall_only();
    test_reset_mid_busy();
    test_stall_count();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
